// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: state encoding,
// coin denominations, default prices and coin-decoding helpers.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CREDIT   = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } vend_state_t;

  localparam logic [7:0] COIN_5      = 8'd5;
  localparam logic [7:0] COIN_10     = 8'd10;
  localparam logic [7:0] COIN_25     = 8'd25;
  localparam logic [7:0] CHANGE_UNIT = 8'd5;

  localparam int DEF_PRICE0      = 50;
  localparam int DEF_PRICE1      = 65;
  localparam int DEF_PRICE2      = 75;
  localparam int DEF_PRICE3      = 100;
  localparam int DEF_MAX_CREDIT  = 100;
  localparam int DEF_DISP_CYCLES = 8;
  localparam int DEF_CHANGE_GAP  = 4;

  function automatic logic [7:0] coin_value(input logic [2:0] c);
    case (c)
      3'b001:  return COIN_5;
      3'b010:  return COIN_10;
      3'b100:  return COIN_25;
      default: return 8'd0;
    endcase
  endfunction

  // True when more than one coin line fires in the same cycle.
  function automatic logic coin_multi(input logic [2:0] c);
    return (c & (c - 3'd1)) != 3'd0;
  endfunction

endpackage

// File: rtl/vend_timer.sv
// Loadable down-counter; o_done is high while the count sits at zero.
// Shared by the dispense window and the change-pulse spacing.
module vend_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_value,
  output logic       o_done
);

  logic [7:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= 8'd0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != 8'd0) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign o_done = (r_count == 8'd0);

endmodule

// File: rtl/vend_controller.sv
// Coin-operated vending controller: accumulates credit, dispenses selected
// items, and pays back residual credit as spaced 5c change pulses.
module vend_controller
  import vend_pkg::*;
#(
  parameter int PRICE0      = DEF_PRICE0,
  parameter int PRICE1      = DEF_PRICE1,
  parameter int PRICE2      = DEF_PRICE2,
  parameter int PRICE3      = DEF_PRICE3,
  parameter int MAX_CREDIT  = DEF_MAX_CREDIT,
  parameter int DISP_CYCLES = DEF_DISP_CYCLES,
  parameter int CHANGE_GAP  = DEF_CHANGE_GAP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] coin_tick,
  input  logic       select_tick,
  input  logic [1:0] item_sel,
  input  logic       cancel_tick,
  output logic [7:0] credit,
  output logic       dispense,
  output logic [1:0] item_out,
  output logic       change_pulse,
  output logic       coin_reject,
  output logic       deny,
  output logic       busy
);

  localparam logic [7:0] L_DISP = 8'(DISP_CYCLES - 1);
  localparam logic [7:0] L_GAP  = 8'(CHANGE_GAP - 1);
  localparam logic [8:0] L_MAX  = 9'(MAX_CREDIT);

  vend_state_t r_state;
  logic [7:0]  r_credit;
  logic        r_dispense;
  logic [1:0]  r_item;
  logic        r_change_pulse;
  logic        r_coin_reject;
  logic        r_deny;
  logic        r_busy;

  logic [7:0]  w_price;
  logic [8:0]  w_sum;
  logic        w_active;
  logic        w_coin_any;
  logic        w_coin_accept;
  logic        w_coin_reject;
  logic        w_cancel_go;
  logic        w_sel_req;
  logic        w_sel_go;
  logic        w_deny;
  logic        w_tmr_load;
  logic [7:0]  w_tmr_value;
  logic        w_tmr_done;

  vend_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_tmr_load),
    .i_value (w_tmr_value),
    .o_done  (w_tmr_done)
  );

  always_comb begin
    w_price = 8'(PRICE0);
    case (item_sel)
      2'd0:    w_price = 8'(PRICE0);
      2'd1:    w_price = 8'(PRICE1);
      2'd2:    w_price = 8'(PRICE2);
      default: w_price = 8'(PRICE3);
    endcase
  end

  // Event arbitration: cancel beats select, any coin suppresses select,
  // and a coin arriving with cancel is always handed back.
  always_comb begin
    w_active      = (r_state == ST_IDLE) || (r_state == ST_CREDIT);
    w_coin_any    = |coin_tick;
    w_sum         = {1'b0, r_credit} + {1'b0, coin_value(coin_tick)};
    w_coin_accept = w_active && w_coin_any && !coin_multi(coin_tick) &&
                    !cancel_tick && (w_sum <= L_MAX);
    w_coin_reject = w_coin_any && !w_coin_accept;
    w_cancel_go   = (r_state == ST_CREDIT) && cancel_tick;
    w_sel_req     = w_active && select_tick && !cancel_tick && !w_coin_any;
    w_sel_go      = w_sel_req && (r_credit >= w_price);
    w_deny        = w_sel_req && !w_sel_go;

    w_tmr_load  = 1'b0;
    w_tmr_value = L_GAP;
    if (w_cancel_go) begin
      w_tmr_load = 1'b1;
    end else if (w_sel_go) begin
      w_tmr_load  = 1'b1;
      w_tmr_value = L_DISP;
    end else if (w_tmr_done && ((r_state == ST_CHANGE) ||
                 ((r_state == ST_DISPENSE) && (r_credit != 8'd0)))) begin
      w_tmr_load = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_credit       <= 8'd0;
      r_dispense     <= 1'b0;
      r_item         <= 2'd0;
      r_change_pulse <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_deny         <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_coin_reject  <= w_coin_reject;
      r_deny         <= w_deny;
      r_change_pulse <= 1'b0;
      case (r_state)
        ST_IDLE, ST_CREDIT: begin
          if (w_cancel_go) begin
            r_state <= ST_CHANGE;
            r_busy  <= 1'b1;
          end else if (w_sel_go) begin
            r_state    <= ST_DISPENSE;
            r_credit   <= r_credit - w_price;
            r_item     <= item_sel;
            r_dispense <= 1'b1;
            r_busy     <= 1'b1;
          end else if (w_coin_accept) begin
            r_state  <= ST_CREDIT;
            r_credit <= w_sum[7:0];
          end
        end
        ST_DISPENSE: begin
          if (w_tmr_done) begin
            r_dispense <= 1'b0;
            if (r_credit != 8'd0) begin
              r_state <= ST_CHANGE;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        ST_CHANGE: begin
          // Credit drops at the edge that ends each change pulse.
          if (r_change_pulse) begin
            r_credit <= (r_credit > CHANGE_UNIT) ? r_credit - CHANGE_UNIT : 8'd0;
            if (r_credit <= CHANGE_UNIT) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else if (w_tmr_done) begin
              r_change_pulse <= 1'b1;
            end
          end else if (w_tmr_done) begin
            r_change_pulse <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign credit       = r_credit;
  assign dispense     = r_dispense;
  assign item_out     = r_item;
  assign change_pulse = r_change_pulse;
  assign coin_reject  = r_coin_reject;
  assign deny         = r_deny;
  assign busy         = r_busy;

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: expected output events are queued as
// stimulus is applied and matched as the controller emits them.
module tb_vend_controller;

  localparam int K_REJ  = 0;
  localparam int K_DENY = 1;
  localparam int K_DISP = 2;
  localparam int K_CHG  = 3;

  typedef struct {
    int kind;
    int a;
    int b;
  } ev_t;

  logic       clk;
  logic       reset;
  logic [2:0] coin_tick;
  logic       select_tick;
  logic [1:0] item_sel;
  logic       cancel_tick;
  logic [7:0] credit;
  logic       dispense;
  logic [1:0] item_out;
  logic       change_pulse;
  logic       coin_reject;
  logic       deny;
  logic       busy;

  ev_t        exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         since = 0;
  int         disp_len = 0;
  logic       prev_chg = 1'b0;
  logic       prev_disp = 1'b0;
  logic [1:0] disp_item = 2'd0;

  vend_controller dut (
    .clk          (clk),
    .reset        (reset),
    .coin_tick    (coin_tick),
    .select_tick  (select_tick),
    .item_sel     (item_sel),
    .cancel_tick  (cancel_tick),
    .credit       (credit),
    .dispense     (dispense),
    .item_out     (item_out),
    .change_pulse (change_pulse),
    .coin_reject  (coin_reject),
    .deny         (deny),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic push(input int kind, input int a, input int b);
    ev_t e;
    e.kind = kind;
    e.a    = a;
    e.b    = b;
    exp_q.push_back(e);
  endtask

  task automatic take(input int kind, input int a, input int b);
    ev_t e;
    n_cmp++;
    assert (exp_q.size() != 0) else begin
      n_bad++;
      $error("FAIL unexpected_event: observed kind %0d (a=%0d b=%0d) expected none", kind, a, b);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk($sformatf("event%0d_a", kind), a, e.a);
      chk($sformatf("event%0d_b", kind), b, e.b);
    end
  endtask

  // Advance one cycle, sample just after the edge and match emitted events.
  task automatic tick();
    logic in_chg;
    @(posedge clk);
    #1;
    in_chg = busy && !dispense;
    if (in_chg && !prev_chg) since = 0;
    else since++;
    if (dispense) disp_len++;
    if (coin_reject) take(K_REJ, int'(credit), 0);
    if (deny) take(K_DENY, int'(credit), 0);
    if (!dispense && prev_disp) begin
      take(K_DISP, disp_len, int'(disp_item));
      disp_len = 0;
    end
    if (change_pulse) begin
      take(K_CHG, since, int'(credit));
      since = 0;
    end
    prev_chg  = in_chg;
    prev_disp = dispense;
    if (dispense) disp_item = item_out;
  endtask

  task automatic coin(input logic [2:0] c);
    coin_tick = c;
    tick();
    coin_tick = 3'b000;
  endtask

  task automatic coin_chk(input logic [2:0] c, input int exp_credit);
    coin(c);
    chk("credit_after_coin", credit, exp_credit);
  endtask

  task automatic sel(input logic [1:0] i);
    select_tick = 1'b1;
    item_sel    = i;
    tick();
    select_tick = 1'b0;
  endtask

  task automatic cancel();
    cancel_tick = 1'b1;
    tick();
    cancel_tick = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (busy && n < max_cyc) begin
      tick();
      n++;
    end
    chk(tag, busy, 0);
  endtask

  initial begin
    reset       = 1'b1;
    coin_tick   = 3'b000;
    select_tick = 1'b0;
    item_sel    = 2'd0;
    cancel_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_credit", credit, 0);
    chk("rst_dispense", dispense, 0);
    chk("rst_item", item_out, 0);
    chk("rst_change", change_pulse, 0);
    chk("rst_reject", coin_reject, 0);
    chk("rst_deny", deny, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    tick();

    // 25+25, buy item 0, coin refused while dispensing
    coin_chk(3'b100, 25);
    coin_chk(3'b100, 50);
    sel(2'd0);
    chk("s1_credit", credit, 0);
    chk("s1_dispense", dispense, 1);
    chk("s1_busy", busy, 1);
    push(K_REJ, 0, 0);
    coin(3'b001);
    push(K_DISP, 8, 0);
    wait_idle("s1_idle", 40);
    chk("s1_credit_end", credit, 0);
    cancel();
    chk("idle_cancel_busy", busy, 0);

    // 85c, buy item 2, two change pulses
    coin_chk(3'b100, 25);
    coin_chk(3'b100, 50);
    coin_chk(3'b100, 75);
    coin_chk(3'b010, 85);
    sel(2'd2);
    chk("s2_credit", credit, 10);
    chk("s2_item", item_out, 2);
    push(K_DISP, 8, 2);
    push(K_CHG, 4, 10);
    push(K_CHG, 4, 5);
    wait_idle("s2_idle", 60);
    chk("s2_credit_end", credit, 0);

    // 90c: over-ceiling coin rejected, unaffordable item denied
    coin_chk(3'b100, 25);
    coin_chk(3'b100, 50);
    coin_chk(3'b100, 75);
    coin_chk(3'b010, 85);
    coin_chk(3'b001, 90);
    push(K_REJ, 90, 0);
    coin(3'b100);
    chk("s3_credit_rej", credit, 90);
    push(K_DENY, 90, 0);
    sel(2'd3);
    chk("s3_credit_deny", credit, 90);
    chk("s3_busy", busy, 0);
    for (int k = 0; k < 18; k++) push(K_CHG, 4, 90 - 5 * k);
    cancel();
    wait_idle("s3_idle", 200);
    chk("s3_credit_end", credit, 0);

    // 15c, cancel with a 25c coin in the same cycle
    coin_chk(3'b010, 10);
    coin_chk(3'b001, 15);
    push(K_REJ, 15, 0);
    push(K_CHG, 4, 15);
    push(K_CHG, 4, 10);
    push(K_CHG, 4, 5);
    cancel_tick = 1'b1;
    coin_tick   = 3'b100;
    tick();
    cancel_tick = 1'b0;
    coin_tick   = 3'b000;
    wait_idle("s4_idle", 60);
    chk("s4_credit_end", credit, 0);

    // Two coin lines at once, then coin together with select
    coin_chk(3'b010, 10);
    push(K_REJ, 10, 0);
    coin(3'b011);
    chk("s5_credit_multi", credit, 10);
    tick();
    coin_tick   = 3'b001;
    select_tick = 1'b1;
    item_sel    = 2'd0;
    tick();
    coin_tick   = 3'b000;
    select_tick = 1'b0;
    chk("s5_coin_with_sel", credit, 15);
    chk("s5_busy", busy, 0);
    push(K_CHG, 4, 15);
    push(K_CHG, 4, 10);
    push(K_CHG, 4, 5);
    cancel();
    wait_idle("s5_idle", 60);

    // Reset during change return with 20c
    coin_chk(3'b010, 10);
    coin_chk(3'b010, 20);
    push(K_CHG, 4, 20);
    cancel();
    repeat (5) tick();
    chk("s6_credit_mid", credit, 15);
    reset = 1'b1;
    #1;
    chk("s6_rst_credit", credit, 0);
    chk("s6_rst_busy", busy, 0);
    chk("s6_rst_change", change_pulse, 0);
    chk("s6_rst_dispense", dispense, 0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (20) tick();
    chk("s6_credit_end", credit, 0);
    chk("s6_busy_end", busy, 0);

    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_bad++;
      $error("FAIL pending_events: observed %0d outstanding expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 The block SHALL have parameter PRICE0, default 50, item 0 price in cents (multiple of 5).
REQ-002 The block SHALL have parameter PRICE1, default 65, item 1 price in cents.
REQ-003 The block SHALL have parameter PRICE2, default 75, item 2 price in cents.
REQ-004 The block SHALL have parameter PRICE3, default 100, item 3 price in cents.
REQ-005 The block SHALL have parameter MAX_CREDIT, default 100, credit ceiling in cents.
REQ-006 The block SHALL have parameter DISP_CYCLES, default 8, dispense pulse length in cycles.
REQ-007 The block SHALL have parameter CHANGE_GAP, default 4, cycles between change pulses.
REQ-008 The block SHALL have the following ports, one per line (name, direction, width, meaning):
clk  in  1  clock;
reset  in  1  asynchronous, active-high reset;
coin_tick  in  3  one-cycle pulses: [0]=5c, [1]=10c, [2]=25c;
select_tick  in  1  one-cycle selection pulse;
item_sel  in  2  item index, sampled with select_tick;
cancel_tick  in  1  one-cycle refund request;
credit  out  8  current credit in cents;
dispense  out  1  item release, high DISP_CYCLES cycles;
item_out  out  2  latched item index, valid while dispense is high;
change_pulse  out  1  one-cycle pulse per 5c returned;
coin_reject  out  1  one-cycle pulse, coin returned;
deny  out  1  one-cycle pulse, insufficient credit;
busy  out  1  high in DISPENSE and CHANGE.
REQ-009 All outputs SHALL be registered.

Function
REQ-010 The FSM SHALL have four states: IDLE (credit 0), CREDIT (credit>0), DISPENSE, CHANGE.
REQ-011 In IDLE/CREDIT, a single coin bit SHALL add its value to credit at the next edge if the sum <= MAX_CREDIT; otherwise coin_reject SHALL pulse next cycle and credit SHALL be unchanged.
REQ-012 If more than one coin_tick bit is set in one cycle, all coins SHALL be rejected (one coin_reject pulse).
REQ-013 A select_tick with credit >= price[item_sel] SHALL enter DISPENSE at the next edge, subtract the price from credit at that edge, and latch item_out.
REQ-014 A select_tick with insufficient credit SHALL pulse deny for one cycle; state and credit SHALL be unchanged.
REQ-015 dispense SHALL be high for exactly DISP_CYCLES cycles starting in the first DISPENSE cycle; afterwards the FSM SHALL go to CHANGE if credit>0, else IDLE.
REQ-016 A cancel_tick in CREDIT SHALL enter CHANGE; in IDLE it SHALL be ignored.
REQ-017 In CHANGE, change_pulse SHALL assert in the cycles CHANGE_GAP, 2*CHANGE_GAP, ... after entry; credit SHALL drop by 5 at the edge ending each pulse; the FSM SHALL return to IDLE at the edge where credit reaches 0.
REQ-018 In DISPENSE/CHANGE every coin SHALL be rejected with a coin_reject pulse; select_tick and cancel_tick SHALL be ignored.
REQ-019 Simultaneous events in one cycle: cancel beats select; a coin with cancel SHALL be rejected; a coin with select SHALL be processed and the select ignored (no deny).
REQ-020 Credit arithmetic SHALL use 8 bits unsigned; credit SHALL never exceed MAX_CREDIT nor underflow.

Reset
REQ-021 Reset SHALL immediately force IDLE, credit=0, item_out=0 and all pulse/level outputs to 0.
REQ-022 Reset mid-DISPENSE or mid-CHANGE SHALL abort at once; residual credit SHALL be discarded and no further pulses emitted.

Structure
REQ-023 Package vend_pkg SHALL hold the state encoding, coin values (5/10/25) and default prices.
REQ-024 Sub-module vend_timer (loadable down-counter with done flag) SHALL time both DISP_CYCLES and CHANGE_GAP.

Verification
REQ-025 Insert 25,25 then select item 0 -> credit 50 -> 0, dispense high 8 cycles, item_out=0, no change, back to IDLE.
REQ-026 Insert 25,25,25,10 then select item 2 -> credit 85 -> 10, dispense 8 cycles, then 2 change_pulses 4 cycles apart, credit 0, IDLE.
REQ-027 Credit 90, insert 25 -> coin_reject pulse, credit stays 90; select item 3 -> deny pulse, credit 90.
REQ-028 Credit 15, cancel_tick with coin_tick=3'b100 same cycle -> coin_reject, 3 change_pulses, credit 0.
REQ-029 coin_tick=3'b011 in one cycle -> single coin_reject, credit unchanged.
REQ-030 Reset asserted mid-CHANGE with credit 20 -> all outputs 0 immediately, no change_pulse after release.
